// File: rtl/sram1rw_param_init.sv
// rtl/sram1rw_param_init.sv - parametrised 1RW SRAM model with lane write mask, output pipe and post-reset clear
//
// Purpose : single-port synchronous SRAM simulation model. After reset a sweep zeroes one word
//           per clock. READY goes high when the sweep finishes, and accesses are accepted only
//           after that point. Reads are read-first. Addresses at or beyond DEPTH drop writes
//           and read back zero.
// Ports   : CE     clock (rising edge)
//           RSTB   asynchronous active-low reset
//           CSB    chip select, active-low
//           WEB    write enable, active-low
//           OEB    read enable, active-low
//           A      word address
//           I      write data
//           WMASK  per-lane write enable
//           O      read data (latency 1, or 2 with OUT_REG=1)
//           READY  high once the clear sweep is complete
//           PERR   per-read parity error pulse (only with SRAM_PARITY_EN)
// Macros  : SRAM_PARITY_EN     stores even parity per lane in mem_par, checks it on read, adds PERR
//           SRAM_TIMING_CHECKS enables the specify block (zero-delay setuphold checks and CE to O path)
module sram1rw_param_init #(
   parameter int WIDTH     = 34,
   parameter int DEPTH     = 64,
   parameter int ADDR_W    = 6,
   parameter int MASK_GRAN = 17,
   parameter int OUT_REG   = 0
) (
   input  logic                         CE,
   input  logic                         RSTB,
   input  logic                         CSB,
   input  logic                         WEB,
   input  logic                         OEB,
   input  logic [ADDR_W-1:0]            A,
   input  logic [WIDTH-1:0]             I,
   input  logic [WIDTH/MASK_GRAN-1:0]   WMASK,
   output logic [WIDTH-1:0]             O,
   output logic                         READY
`ifdef SRAM_PARITY_EN
   ,
   output logic                         PERR
`endif
);

   localparam int                LANES    = WIDTH / MASK_GRAN;
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   generate
      if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
         $fatal(1, "sram1rw_param_init: WIDTH must be a multiple of MASK_GRAN");
      end
      if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr
         $fatal(1, "sram1rw_param_init: ADDR_W too narrow for DEPTH");
      end
   endgenerate

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              clr_en;
   logic              in_range, rd_en, wr_en;
   logic [WIDTH-1:0]  rd_word;
   logic              pipe_vld_q;
   logic [WIDTH-1:0]  pipe_data_q;

   logic [WIDTH-1:0]  mem [DEPTH];

   // Clear sweep FSM: CLEAR walks the pointer across every word, then RUN until the next reset.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      clr_en    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_en = 1'b1;
            if (clr_ptr_q == LAST_PTR) state_d = ST_RUN;
            else                       clr_ptr_d = clr_ptr_q + ADDR_W'(1);
         end
         ST_RUN:  ;
         default: state_d = ST_CLEAR;
      endcase
   end

   assign READY    = (state_q == ST_RUN);
   assign in_range = ({1'b0, A} < DEPTH_X);
   assign rd_en    = READY && !CSB && !OEB;
   assign wr_en    = READY && !CSB && !WEB && in_range;
   // Out-of-range reads return zero instead of indexing past the array.
   assign rd_word  = in_range ? mem[A] : '0;

   // Storage has no reset; the sweep provides the zero state. The read path samples
   // mem before this edge's write lands, so a same-address read/write is read-first.
   always_ff @(posedge CE) begin
      if (clr_en) begin
         mem[clr_ptr_q] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < LANES; k++) begin
            if (WMASK[k]) mem[A][k*MASK_GRAN +: MASK_GRAN] <= I[k*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // Output path: O only changes when a read completes, otherwise it holds.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         O           <= '0;
         pipe_vld_q  <= 1'b0;
         pipe_data_q <= '0;
      end else if (OUT_REG != 0) begin
         pipe_vld_q <= rd_en;
         if (rd_en)      pipe_data_q <= rd_word;
         if (pipe_vld_q) O           <= pipe_data_q;
      end else if (rd_en) begin
         O <= rd_word;
      end
   end

`ifdef SRAM_PARITY_EN
   logic [LANES-1:0] mem_par [DEPTH];
   logic [LANES-1:0] rd_par;
   logic             rd_bad;
   logic             perr_pipe_q;

   function automatic logic [LANES-1:0] lane_parity(input logic [WIDTH-1:0] w);
      logic [LANES-1:0] p;
      p = '0;
      for (int k = 0; k < LANES; k++) p[k] = ^w[k*MASK_GRAN +: MASK_GRAN];
      return p;
   endfunction

   // Out-of-range reads yield zero data with zero parity, so they never flag an error.
   assign rd_par = in_range ? mem_par[A] : '0;
   assign rd_bad = rd_en && (lane_parity(rd_word) != rd_par);

   always_ff @(posedge CE) begin
      if (clr_en) begin
         mem_par[clr_ptr_q] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < LANES; k++) begin
            if (WMASK[k]) mem_par[A][k] <= ^I[k*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // PERR goes through the same number of stages as O, so the pulse lines up with the bad word.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         perr_pipe_q <= 1'b0;
         PERR        <= 1'b0;
      end else begin
         perr_pipe_q <= rd_bad;
         PERR        <= (OUT_REG != 0) ? perr_pipe_q : rd_bad;
      end
   end
`endif

`ifdef SRAM_TIMING_CHECKS
   specify
      (CE *> O) = 0;
      $setuphold(posedge CE, I, 0, 0);
      $setuphold(posedge CE, A, 0, 0);
      $setuphold(posedge CE, WMASK, 0, 0);
      $setuphold(posedge CE, CSB, 0, 0);
      $setuphold(posedge CE, WEB, 0, 0);
      $setuphold(posedge CE, OEB, 0, 0);
   endspecify
`endif

endmodule

// File: tb/tb_sram1rw_param_init.sv
// tb/tb_sram1rw_param_init.sv - scoreboard bench for sram1rw_param_init (DEPTH 64 / OUT_REG 0 and DEPTH 48 / OUT_REG 1)
`timescale 1ns/1ps
module tb_sram1rw_param_init;
   localparam int W  = 34;
   localparam int LN = 2;
   localparam int D0 = 64;
   localparam int D1 = 48;

   logic          ce = 1'b0;
   logic          rstb0, rstb1, csb, web, oeb;
   logic [5:0]    a;
   logic [W-1:0]  din;
   logic [LN-1:0] wmask;
   logic [W-1:0]  o0, o1;
   logic          ready0, ready1;
   logic          perr0, perr1;

   always #5 ce = ~ce;

   sram1rw_param_init #(.WIDTH(W), .DEPTH(D0), .ADDR_W(6), .MASK_GRAN(17), .OUT_REG(0)) dut0 (
      .CE(ce), .RSTB(rstb0), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .WMASK(wmask),
      .O(o0), .READY(ready0)
`ifdef SRAM_PARITY_EN
      , .PERR(perr0)
`endif
   );

   sram1rw_param_init #(.WIDTH(W), .DEPTH(D1), .ADDR_W(6), .MASK_GRAN(17), .OUT_REG(1)) dut1 (
      .CE(ce), .RSTB(rstb1), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .WMASK(wmask),
      .O(o1), .READY(ready1)
`ifdef SRAM_PARITY_EN
      , .PERR(perr1)
`endif
   );

`ifndef SRAM_PARITY_EN
   assign perr0 = 1'b0;
   assign perr1 = 1'b0;
`endif

   typedef struct {
      int           due;
      logic [W-1:0] data;
      logic         perr;
   } exp_t;

   exp_t         q0[$];
   exp_t         q1[$];
   logic [W-1:0] lastv [2];
   logic [W-1:0] model1 [D1];
   int           cyc = 0;
   int           n0 = 0;
   int           n1 = 0;
   int           checks = 0;
   int           fails = 0;
   bit           mon_on = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Edge counters since each reset release model when READY is due.
   always @(posedge ce) begin
      cyc++;
      n0 = rstb0 ? n0 + 1 : 0;
      n1 = rstb1 ? n1 + 1 : 0;
   end

   task automatic mon(input int id, input logic [W-1:0] o, input logic pe, input logic rdy,
                      input logic rst_n, input int n, input int depth);
      exp_t  e;
      bit    have;
      string tag;
      have = 0;
      tag  = (id == 0) ? "d0" : "d1";
      e    = '{due: 0, data: '0, perr: 1'b0};
      if (id == 0) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
      end
      if (have) begin
         chk($sformatf("%s_rdata", tag), o, e.data);
         lastv[id] = e.data;
      end else begin
         if (!rst_n) lastv[id] = '0;
         chk($sformatf("%s_hold", tag), o, lastv[id]);
      end
`ifdef SRAM_PARITY_EN
      chk($sformatf("%s_perr", tag), pe, have ? e.perr : 1'b0);
`endif
      chk($sformatf("%s_ready", tag), rdy, (rst_n && n >= depth));
   endtask

   always @(negedge ce) begin
      if (mon_on) begin
         mon(0, o0, perr0, ready0, rstb0, n0, D0);
         mon(1, o1, perr1, ready1, rstb1, n1, D1);
      end
   end

   // One access cycle; e0/e1 are the hand-computed read results for the two instances.
   task automatic op(input bit cs, input bit rd, input bit wr, input logic [5:0] addr,
                     input logic [W-1:0] d, input logic [LN-1:0] m,
                     input logic [W-1:0] e0, input logic [W-1:0] e1, input logic pe);
      @(posedge ce); #1;
      csb = !cs; oeb = !rd; web = !wr; a = addr; din = d; wmask = m;
      if (cs && rd) begin
         q0.push_back('{due: cyc + 1, data: e0, perr: pe});
         q1.push_back('{due: cyc + 2, data: e1, perr: pe});
      end
      if (cs && wr && addr < D1) begin
         if (m[0]) model1[addr][16:0]  = d[16:0];
         if (m[1]) model1[addr][33:17] = d[33:17];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge ce); #1;
         csb = 1'b1; oeb = 1'b1; web = 1'b1;
      end
   endtask

   initial begin
      rstb0 = 1'b0; rstb1 = 1'b0;
      csb = 1'b1; web = 1'b1; oeb = 1'b1; a = '0; din = '0; wmask = '0;
      lastv[0] = '0; lastv[1] = '0;
      for (int k = 0; k < D1; k++) model1[k] = '0;

      @(posedge ce); #1;
      mon_on = 1;
      repeat (2) @(posedge ce);
      #1;
      rstb0 = 1'b1; rstb1 = 1'b1;

      // Interrupt the DEPTH=48 sweep after 20 words; it must restart from word 0.
      while (n1 < 20) begin @(posedge ce); #1; end
      rstb1 = 1'b0;
      @(posedge ce); #1;
      rstb1 = 1'b1;

      for (int t = 0; t < 300 && !(ready0 && ready1); t++) begin @(posedge ce); #1; end
      chk("both_ready", {ready0, ready1}, 2'b11);

      // Fresh memory reads as zero everywhere, including the out-of-range word on dut1.
      op(1, 1, 0, 6'd0,  '0, 2'b00, 34'h0, 34'h0, 1'b0);
      op(1, 1, 0, 6'd5,  '0, 2'b00, 34'h0, 34'h0, 1'b0);
      op(1, 1, 0, 6'd47, '0, 2'b00, 34'h0, 34'h0, 1'b0);
      op(1, 1, 0, 6'd63, '0, 2'b00, 34'h0, 34'h0, 1'b0);

      // Full write then read back.
      op(1, 0, 1, 6'd5, 34'h2_AAAA_5555, 2'b11, '0, '0, 1'b0);
      op(1, 1, 0, 6'd5, '0, 2'b00, 34'h2_AAAA_5555, 34'h2_AAAA_5555, 1'b0);
      // Lower lane only: upper 17 bits survive.
      op(1, 0, 1, 6'd5, 34'h0, 2'b01, '0, '0, 1'b0);
      op(1, 1, 0, 6'd5, '0, 2'b00, 34'h2_AAAA_0000, 34'h2_AAAA_0000, 1'b0);

      // Read-first on a simultaneous read and write.
      op(1, 0, 1, 6'd9, 34'h1, 2'b11, '0, '0, 1'b0);
      op(1, 1, 1, 6'd9, 34'h3, 2'b11, 34'h1, 34'h1, 1'b0);
      op(1, 1, 0, 6'd9, '0, 2'b00, 34'h3, 34'h3, 1'b0);

      // WMASK=0 is a no-op; upper-lane-only write clears just bits 33:17.
      op(1, 0, 1, 6'd7, 34'h3_FFFF_FFFF, 2'b11, '0, '0, 1'b0);
      op(1, 0, 1, 6'd7, 34'h0, 2'b00, '0, '0, 1'b0);
      op(1, 1, 0, 6'd7, '0, 2'b00, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b0);
      op(1, 0, 1, 6'd7, 34'h0, 2'b10, '0, '0, 1'b0);
      op(1, 1, 0, 6'd7, '0, 2'b00, 34'h0_0001_FFFF, 34'h0_0001_FFFF, 1'b0);

      // Deselected cycle with read/write strobes low: no read, no write, O holds.
      op(0, 1, 1, 6'd9, 34'h2_0000_0000, 2'b11, '0, '0, 1'b0);
      idle(2);
      op(1, 1, 0, 6'd9, '0, 2'b00, 34'h3, 34'h3, 1'b0);

      // Out-of-range for dut1 (DEPTH 48), in-range for dut0 (DEPTH 64).
      op(1, 0, 1, 6'd50, 34'h1_2345_6789, 2'b11, '0, '0, 1'b0);
      op(1, 1, 0, 6'd50, '0, 2'b00, 34'h1_2345_6789, 34'h0, 1'b0);
      op(1, 0, 1, 6'd63, 34'h2_0000_0001, 2'b11, '0, '0, 1'b0);
      op(1, 1, 0, 6'd63, '0, 2'b00, 34'h2_0000_0001, 34'h0, 1'b0);
      op(1, 0, 1, 6'd47, 34'h0_DEAD_BEEF, 2'b11, '0, '0, 1'b0);
      // Back-to-back reads exercise the output pipeline.
      op(1, 1, 0, 6'd47, '0, 2'b00, 34'h0_DEAD_BEEF, 34'h0_DEAD_BEEF, 1'b0);
      op(1, 1, 0, 6'd5,  '0, 2'b00, 34'h2_AAAA_0000, 34'h2_AAAA_0000, 1'b0);
      op(1, 1, 0, 6'd0,  '0, 2'b00, 34'h0, 34'h0, 1'b0);
      idle(4);

`ifdef SRAM_PARITY_EN
      op(1, 0, 1, 6'd2, 34'h0_0000_0001, 2'b11, '0, '0, 1'b0);
      idle(2);
      dut0.mem[2][0] = ~dut0.mem[2][0];
      dut1.mem[2][0] = ~dut1.mem[2][0];
      model1[2][0]   = ~model1[2][0];
      op(1, 1, 0, 6'd2, '0, 2'b00, 34'h0, 34'h0, 1'b1);
      idle(3);
      op(1, 1, 0, 6'd9, '0, 2'b00, 34'h3, 34'h3, 1'b0);
      op(1, 1, 0, 6'd7, '0, 2'b00, 34'h0_0001_FFFF, 34'h0_0001_FFFF, 1'b0);
      idle(4);
`endif

      // Dropped write at A=50 must not alias into dut1's storage.
      for (int k = 0; k < D1; k++) chk($sformatf("d1_mem[%0d]", k), dut1.mem[k], model1[k]);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);

      mon_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
